// File: rtl/des_fp_serializer.sv
// DES output stage: forms R16||L16, applies IP^-1, streams the ciphertext MSB byte first.
// Optional macro DES_FP_PARITY_EN adds out_par, the XOR of the current out_byte.
module des_fp_serializer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_l,
  input  logic [31:0]      in_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
`ifdef DES_FP_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  // Source DES bit position for each output bit 1..64; DES bit 1 is the vector MSB.
  localparam int unsigned FP_TAB [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
  };

  function automatic logic [63:0] inv_ip(input logic [63:0] pre);
    logic [63:0] fp;
    fp = '0;
    for (int i = 0; i < 64; i++) begin
      fp[6'(63 - i)] = pre[6'(64 - FP_TAB[6'(i)])];
    end
    return fp;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [63:0]      hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      fp;
  logic             send;
  logic             take;

  always_comb begin
    fp       = inv_ip({in_r, in_l});
    send     = (state_q == SEND);
    // Ready during the final accepted byte lets the next block follow without a bubble.
    in_ready = !rst && (!send || (k_q == 3'd7 && out_ready));
    take     = in_valid && in_ready;
    state_d  = state_q;
    k_d      = k_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = SEND;
          k_d     = 3'd0;
          hold_d  = fp;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (k_q != 3'd7) begin
            k_d = k_q + 3'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            k_d   = 3'd0;
            if (take) hold_d = fp;
            else      state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte k is bits 8k+1..8k+8 in DES order, i.e. counted down from the MSB.
  always_comb begin
    out_valid = send;
    out_last  = send && (k_q == 3'd7);
    out_byte  = send ? 8'(hold_q >> {~k_q, 3'b000}) : 8'h00;
  end

`ifdef DES_FP_PARITY_EN
  assign out_par = ^out_byte;
`endif

  assign blk_cnt = cnt_q;

endmodule

// File: tb/tb_des_fp_serializer.sv
// Bench for des_fp_serializer: vector table plus scoreboard of expected bytes.
module tb_des_fp_serializer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_l;
  logic [31:0] in_r;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [15:0] blk_cnt;
`ifdef DES_FP_PARITY_EN
  logic        out_par;
`endif

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  bit bp_mode = 1'b0;
  logic [8:0] sb [$];

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [63:0] exp;
  } vec_t;
  vec_t vt [5];

  always #5 clk = ~clk;

  des_fp_serializer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_l(in_l), .in_r(in_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
`ifdef DES_FP_PARITY_EN
    .out_par(out_par),
`endif
    .blk_cnt(blk_cnt)
  );

  // IP^-1 rebuilt from its row/column structure rather than a lookup table.
  function automatic logic [63:0] model(input logic [31:0] l, input logic [31:0] r);
    logic [63:0] pre;
    logic [63:0] fp;
    int row, col, t;
    pre = {r, l};
    fp = '0;
    for (int i = 1; i <= 64; i++) begin
      row = (i - 1) / 8;
      col = (i - 1) % 8;
      t = (col % 2 == 0) ? (40 - row + 4 * col) : (8 - row + 4 * (col - 1));
      fp[64 - i] = pre[64 - t];
    end
    return fp;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [63:0] exp);
    for (int k = 0; k < 8; k++) sb.push_back({(k == 7), exp[63 - 8 * k -: 8]});
    exp_cnt++;
  endtask

  // Called just after a rising edge; returns just after the transfer edge.
  task automatic send_block(input logic [31:0] l, input logic [31:0] r,
                            input logic [63:0] exp, input bit drop);
    int n;
    n = 0;
    in_l = l;
    in_r = r;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    check("in_handshake", in_ready, 1'b1);
    @(posedge clk);
    push(exp);
    #1;
    if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n >= 400), 1'b0);
    @(negedge clk);
    check("idle_after_block", out_valid, 1'b0);
    check("blk_cnt", blk_cnt, exp_cnt[15:0]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? (ph == 0) : 1'b1;
      ph = (ph + 1) % 3;
    end
  end

  logic       stalled = 1'b0;
  logic [7:0] st_byte = 8'h00;
  logic [8:0] e;
  always @(negedge clk) begin
    if (stalled) check("stall_hold", {out_valid, out_byte}, {1'b1, st_byte});
    stalled = !rst && out_valid && !out_ready;
    st_byte = out_byte;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte: got %h expected none at %0t", out_byte, $time);
      end else begin
        e = sb.pop_front();
        check("byte", out_byte, e[7:0]);
        check("last", out_last, e[8]);
`ifdef DES_FP_PARITY_EN
        check("par", out_par, ^e[7:0]);
`endif
      end
    end
  end

  initial begin
    vec_t v1;
    int gaps, rdy_first, rdy_idx;
    in_valid = 1'b0;
    in_l = '0;
    in_r = '0;
    rst = 1'b1;
    vt[0] = '{32'h43423234, 32'h0A4CD995, 64'h85E813540F0AB405};
    vt[1] = '{32'h00000000, 32'h00000000, 64'h0};
    vt[2] = '{32'h00000000, 32'h80000000, model(32'h00000000, 32'h80000000)};
    for (int i = 3; i < 5; i++) begin
      vt[i].l = $urandom;
      vt[i].r = $urandom;
      vt[i].exp = model(vt[i].l, vt[i].r);
    end

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_byte", out_byte, 8'h00);
    check("rst_blk_cnt", blk_cnt, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1'b1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      send_block(vt[i].l, vt[i].r, vt[i].exp, 1'b1);
      @(negedge clk);
      check("latency_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
      wait_drain();
    end

    bp_mode = 1'b1;
    send_block(vt[0].l, vt[0].r, vt[0].exp, 1'b1);
    wait_drain();
    send_block(vt[4].l, vt[4].r, vt[4].exp, 1'b1);
    wait_drain();
    bp_mode = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back blocks with in_valid held high across the handover.
    v1.l = $urandom;
    v1.r = $urandom;
    v1.exp = model(v1.l, v1.r);
    in_l = vt[0].l;
    in_r = vt[0].r;
    in_valid = 1'b1;
    @(negedge clk);
    check("b2b_ready_idle", in_ready, 1'b1);
    @(posedge clk);
    push(vt[0].exp);
    #1;
    in_l = v1.l;
    in_r = v1.r;
    gaps = 0;
    rdy_first = 0;
    rdy_idx = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!out_valid) gaps++;
      if (i < 8 && in_ready) begin
        rdy_first++;
        rdy_idx = i;
      end
      if (in_ready && in_valid) begin
        @(posedge clk);
        push(v1.exp);
        #1;
        in_valid = 1'b0;
      end
    end
    check("b2b_gaps", gaps, 0);
    check("b2b_ready_pulses", rdy_first, 1);
    check("b2b_ready_at_byte7", rdy_idx, 7);
    @(posedge clk);
    #1;
    wait_drain();

    // Reset after byte 3 has been accepted.
    send_block(vt[3].l, vt[3].r, vt[3].exp, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_blk_cnt", blk_cnt, 16'h0);
    check("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_block(vt[4].l, vt[4].r, vt[4].exp, 1'b1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
